window_threshold_detector: RTL
==============================

# window_threshold_detector

Parametrised, sequential successor to the 12-bit user-input reduction block. It accumulates a configurable window of `user_in` samples after a start pulse, then compares the sum against a threshold latched at start. It reports the result on `user_out` with a one-cycle `done` strobe. It sits between a user-data source with a valid qualifier and control logic that needs a registered pass/fail decision per window.

## Interface
- `WIDTH`, default 12: sample width of `user_in`.
- `WINDOW`, default 10: samples per window; must be ≥ 1.
- `ACC_W`, default 16: accumulator, threshold and `sum` width; must be ≥ `WIDTH`.

Clock and reset: one clock; reset is synchronous and active-low.

- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `start`, in, 1: begin a window; accepted only in IDLE.
- `threshold`, in, `ACC_W`: compare value, latched when `start` is accepted.
- `user_in`, in, `WIDTH`: sample data, unsigned.
- `in_valid`, in, 1: `user_in` is valid this cycle.
- `busy`, out, 1: window in progress (state ACCUM).
- `done`, out, 1: one-cycle completion strobe.
- `user_out`, out, 1: registered result, high when `sum` ≥ latched threshold.
- `sum`, out, `ACC_W`: registered final window sum.

## Operation
- **States.**
  - IDLE → ACCUM on `start`.
  - ACCUM → IDLE on acceptance of sample number `WINDOW`.
- **Start.** Accepting `start` clears the accumulator and the sample counter (width `$clog2(WINDOW+1)`) and latches `threshold`. `start` in ACCUM is ignored.
- **Samples.** In ACCUM, each cycle with `in_valid`=1 adds `user_in`, zero-extended to `ACC_W`, to the accumulator and increments the counter. Cycles with `in_valid`=0 change nothing; gaps of any length are legal. `in_valid` in IDLE is ignored.
- **Final sample.** On the edge accepting sample `WINDOW`:
  - the next accumulator value is written to `sum`;
  - `user_out` <= (next value ≥ latched threshold), unsigned compare;
  - `done` <= 1;
  - the state returns to IDLE.
- **Result hold.** `user_out` and `sum` hold until the next window completes; they are not cleared by `start`.
- **Arithmetic.** Overflow of the accumulator beyond `ACC_W` bits is handled per Configuration.
- **`WINDOW`=1.** The first valid sample completes the window.
- **Reset values.** `rst_n`=0 at any edge, including mid-window, forces:
  - state IDLE, `busy`=0, `done`=0, `user_out`=0, `sum`=0;
  - accumulator, counter and latched threshold all 0.
  
  A window interrupted by reset produces no `done`.

## Timing
- `busy` rises the cycle after the `start` edge. It falls in the same cycle `done` rises.
- `done` is high exactly one cycle: the cycle after the edge that accepted the final sample. `user_out` and `sum` are valid in that cycle.
- Minimum window length from `start` to `done` is `WINDOW`+1 cycles, with `in_valid` held high from the cycle after `start`.
- `start` asserted during the `done` cycle is accepted (state is IDLE), giving back-to-back windows with no dead cycle.
- `start` and `in_valid` asserted together in IDLE: start is accepted and the sample is not counted.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `WTD_SAT_EN` defined: the accumulator saturates at 2^`ACC_W`−1. Once saturated it stays saturated for the rest of the window.
- `WTD_SAT_EN` undefined: the accumulator wraps modulo 2^`ACC_W`.
- Nothing else differs between the two builds.

## Test plan
1. **Incrementing samples, threshold met.** `WIDTH`=12, `WINDOW`=10, `ACC_W`=16, `threshold`=825. `start`, then samples 0x00F, 0x01E, … 0x096 (step 0xF) with `in_valid` held high → `done` one cycle later, `sum`=0x339, `user_out`=1, `busy` low in the `done` cycle.
2. **Threshold miss with gaps.** Same samples, `threshold`=826, `in_valid` toggled 1/0 → `sum`=0x339, `user_out`=0, `done` after the 10th valid sample only. Changing `threshold` mid-window has no effect.
3. **Overflow.** `ACC_W`=12, ten samples of 0xFFF:
   - with `WTD_SAT_EN`: `sum`=0xFFF;
   - without: `sum`=0xFF6.
4. **Reset mid-window.** After 5 samples drive `rst_n`=0 for one cycle → `busy`=0, `done`=0, `user_out`=0, `sum`=0; no `done` follows even if 5 more samples arrive without a new `start`.
5. **Start handling.** Extra `start` pulses during ACCUM are ignored (same `sum` as scenario 1). `start` in the `done` cycle begins a new window immediately. `WINDOW`=1 with sample 0x123 and `threshold` 0x123 → `sum`=0x123, `user_out`=1.

Source files
------------

// File: rtl/window_threshold_detector.sv
// Windowed accumulator: sums WINDOW valid samples after start and compares the
// total against a threshold latched at start. Define WTD_SAT_EN to saturate the accumulator.
module window_threshold_detector #(
  parameter int WIDTH  = 12,
  parameter int WINDOW = 10,
  parameter int ACC_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] threshold,
  input  logic [WIDTH-1:0] user_in,
  input  logic             in_valid,
  output logic             busy,
  output logic             done,
  output logic             user_out,
  output logic [ACC_W-1:0] sum,
  output logic             state_dbg
);

  // Handshake: user_in is consumed on every rising edge where in_valid=1 and the
  // block is in ACCUM; there is no back-pressure, so the source never stalls.

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             last;

`ifdef WTD_SAT_EN
  logic [ACC_W:0] acc_wide;
  always_comb begin
    acc_wide = {1'b0, acc} + (ACC_W + 1)'(user_in);
    acc_next = acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_next = acc + ACC_W'(user_in);
  end
`endif

  assign take      = (state == ACCUM) && in_valid;
  assign last      = take && (cnt == LAST_IDX);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      thr_q    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      user_out <= 1'b0;
      sum      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            thr_q <= threshold;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (take) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
          // Final sample: publish result from the next accumulator value.
          if (last) begin
            sum      <= acc_next;
            user_out <= (acc_next >= thr_q);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
